// File: rtl/mmio_xbar_if.sv
// Bundle of CPU-side and peripheral-side signals around the MMIO crossbar.
// The slave modport is the crossbar's own view: it serves CPU requests and
// drives the peripheral strobes. The master modport is the surrounding
// system: the CPU issuing requests and the peripherals answering them.
interface mmio_xbar_if #(
    parameter int N_SLAVE = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic                      m_en;
    logic                      m_we;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_ready;
    logic                      m_rvalid;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_err;
    logic [N_SLAVE-1:0]        s_en;
    logic [N_SLAVE-1:0]        s_we;
    logic [ADDR_W*N_SLAVE-1:0] s_addr;
    logic [DATA_W*N_SLAVE-1:0] s_wdata;
    logic [N_SLAVE-1:0]        s_ack;
    logic [DATA_W*N_SLAVE-1:0] s_rdata;

    modport slave (
        input  m_en, m_we, m_addr, m_wdata, s_ack, s_rdata,
        output m_ready, m_rvalid, m_rdata, m_err, s_en, s_we, s_addr, s_wdata
    );

    modport master (
        output m_en, m_we, m_addr, m_wdata, s_ack, s_rdata,
        input  m_ready, m_rvalid, m_rdata, m_err, s_en, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/mmio_xbar.sv
// MMIO router: one CPU master fanned out to N_SLAVE peripherals, decoded on an
// address byte. One transaction in flight; registered request and response,
// with unmapped-address and timeout errors.
module mmio_xbar #(
    parameter int N_SLAVE = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_HI  = 31,
    parameter int SEL_LO  = 24,
    parameter logic [N_SLAVE*(SEL_HI-SEL_LO+1)-1:0] SLAVE_BASE = {8'h09, 8'h06},
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    mmio_xbar_if.slave  bus
);
    localparam int FLD_W = SEL_HI - SEL_LO + 1;
    localparam int SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic [N_SLAVE-1:0] hit;
    logic               hit_any;
    logic [SEL_W-1:0]   hit_sel;
    logic               ack_sel;
    logic [DATA_W-1:0]  rdata_sel;
    logic               timeout_hit;

    // Per-slave address match on the decoded field
    generate
        for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_decode
            assign hit[gi] = (bus.m_addr[SEL_HI:SEL_LO] == SLAVE_BASE[gi*FLD_W +: FLD_W]);
        end
    endgenerate

    assign hit_any = |hit;

    // Priority encode: scanning downward lets the lowest matching index win
    always_comb begin
        hit_sel = '0;
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if (hit[i]) hit_sel = SEL_W'(i);
        end
    end

    // Only the selected slave's ack/data can complete a transfer
    assign ack_sel     = bus.s_ack[sel_reg];
    assign rdata_sel   = bus.s_rdata[int'(sel_reg)*DATA_W +: DATA_W];
    assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_reg) + 1) == TIMEOUT);

    // Transaction FSM with request latches, timeout counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.m_en) begin
                        addr_reg  <= bus.m_addr;
                        wdata_reg <= bus.m_wdata;
                        we_reg    <= bus.m_we;
                        sel_reg   <= hit_sel;
                        cnt_reg   <= '0;
                        if (hit_any) begin
                            state_reg <= ST_BUSY;
                        end else begin
                            rdata_reg <= '0;
                            err_reg   <= 1'b1;
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    // An ack arriving on the timeout cycle still completes normally
                    if (ack_sel) begin
                        rdata_reg <= we_reg ? '0 : rdata_sel;
                        err_reg   <= 1'b0;
                        state_reg <= ST_RESP;
                    end else if (timeout_hit) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_ready  = bus.m_en && (state_reg == ST_IDLE);
    assign bus.m_rvalid = (state_reg == ST_RESP);
    assign bus.m_rdata  = rdata_reg;
    assign bus.m_err    = err_reg;

    // Drive only the selected slave's slice; every other slice stays zero
    generate
        for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_slave
            logic active;
            assign active = (state_reg == ST_BUSY) && (sel_reg == SEL_W'(gi));
            assign bus.s_en[gi]                      = active;
            assign bus.s_we[gi]                      = active && we_reg;
            assign bus.s_addr[gi*ADDR_W +: ADDR_W]   = active ? addr_reg  : '0;
            assign bus.s_wdata[gi*DATA_W +: DATA_W]  = active ? wdata_reg : '0;
        end
    endgenerate
endmodule

// File: tb/tb_mmio_xbar.sv
// Self-checking bench for mmio_xbar: one DUT with distinct slave bases and a
// short timeout, one with both slaves on the same base to exercise priority.
module tb_mmio_xbar;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mmio_xbar_if #(.N_SLAVE(2), .ADDR_W(32), .DATA_W(32)) bus0 ();
    mmio_xbar_if #(.N_SLAVE(2), .ADDR_W(32), .DATA_W(32)) bus1 ();

    mmio_xbar #(.N_SLAVE(2), .ADDR_W(32), .DATA_W(32), .SEL_HI(31), .SEL_LO(24),
                .SLAVE_BASE(16'h0906), .TIMEOUT(4))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    mmio_xbar #(.N_SLAVE(2), .ADDR_W(32), .DATA_W(32), .SEL_HI(31), .SEL_LO(24),
                .SLAVE_BASE(16'h0606), .TIMEOUT(4))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- signal access helpers ----------------
    task automatic set_req(input int dut, input logic en, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (dut == 0) begin
            bus0.m_en = en; bus0.m_we = we; bus0.m_addr = addr; bus0.m_wdata = wdata;
        end else begin
            bus1.m_en = en; bus1.m_we = we; bus1.m_addr = addr; bus1.m_wdata = wdata;
        end
    endtask

    task automatic set_ack(input int dut, input logic [1:0] ack, input logic [63:0] rd);
        if (dut == 0) begin
            bus0.s_ack = ack; bus0.s_rdata = rd;
        end else begin
            bus1.s_ack = ack; bus1.s_rdata = rd;
        end
    endtask

    function automatic logic [1:0] get_en(input int dut);
        return (dut == 0) ? bus0.s_en : bus1.s_en;
    endfunction
    function automatic logic [1:0] get_we(input int dut);
        return (dut == 0) ? bus0.s_we : bus1.s_we;
    endfunction
    function automatic logic [63:0] get_addr(input int dut);
        return (dut == 0) ? bus0.s_addr : bus1.s_addr;
    endfunction
    function automatic logic [63:0] get_wdata(input int dut);
        return (dut == 0) ? bus0.s_wdata : bus1.s_wdata;
    endfunction
    function automatic logic get_rvalid(input int dut);
        return (dut == 0) ? bus0.m_rvalid : bus1.m_rvalid;
    endfunction
    function automatic logic get_ready(input int dut);
        return (dut == 0) ? bus0.m_ready : bus1.m_ready;
    endfunction
    function automatic logic [31:0] get_rdata(input int dut);
        return (dut == 0) ? bus0.m_rdata : bus1.m_rdata;
    endfunction
    function automatic logic get_err(input int dut);
        return (dut == 0) ? bus0.m_err : bus1.m_err;
    endfunction

    // Issue one request and play the slave side: ack_slave acks once s_en has been
    // seen for ack_delay cycles (negative = never); spur is ORed onto s_ack throughout.
    // lat counts cycles from the accept edge to the cycle showing m_rvalid.
    task automatic run_txn(input int dut, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_slave, input int ack_delay,
                           input logic [31:0] ack_data, input logic [1:0] spur,
                           output int lat, output int en_cycles, output logic [1:0] en_or,
                           output logic [1:0] en_first, output logic [1:0] we_first,
                           output logic [63:0] addr_first, output logic [63:0] wdata_first,
                           output logic [31:0] rdata, output logic err, output logic rv_twice);
        logic [63:0] rd_bus;
        logic [1:0]  ack_bit;
        int          wait_cnt;
        bit          got;
        rd_bus = {2{32'h0BAD_0BAD}};
        ack_bit = 2'b00;
        if (ack_slave >= 0) begin
            rd_bus[ack_slave*32 +: 32] = ack_data;
            ack_bit[ack_slave] = 1'b1;
        end
        lat = 0; en_cycles = 0; en_or = 2'b00; en_first = 2'b00; we_first = 2'b00;
        addr_first = '0; wdata_first = '0; rdata = '0; err = 1'b0; rv_twice = 1'b0;
        @(posedge clk); #1;
        set_req(dut, 1'b1, we, addr, wdata);
        set_ack(dut, spur, rd_bus);
        wait_cnt = 0;
        do begin
            @(negedge clk);
            wait_cnt++;
        end while (!get_ready(dut) && wait_cnt < 20);
        if (!get_ready(dut)) begin
            checks++; errors++;
            $display("FAIL accept_wait: m_ready got 0 required 1 within 20 cycles");
            set_req(dut, 1'b0, 1'b0, 32'h0, 32'h0);
            return;
        end
        @(posedge clk); #1;
        set_req(dut, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ack(dut, ((ack_delay >= 0 && en_cycles >= ack_delay) ? ack_bit : 2'b00) | spur, rd_bus);
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (get_en(dut) != 2'b00) begin
                if (en_cycles == 0) begin
                    en_first = get_en(dut); we_first = get_we(dut);
                    addr_first = get_addr(dut); wdata_first = get_wdata(dut);
                end
                en_cycles++;
                en_or |= get_en(dut);
            end
            if (get_rvalid(dut)) begin
                got = 1'b1;
                rdata = get_rdata(dut);
                err = get_err(dut);
            end else begin
                @(posedge clk); #1;
                set_ack(dut, ((ack_delay >= 0 && en_cycles >= ack_delay) ? ack_bit : 2'b00) | spur, rd_bus);
            end
        end
        @(posedge clk); #1;
        set_ack(dut, 2'b00, 64'h0);
        @(negedge clk);
        rv_twice = get_rvalid(dut);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_wait: m_rvalid got 0 required 1 within 40 cycles (addr %h)", addr);
        end
        $display("txn dut=%0d we=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d s_en_cycles=%0d",
                 dut, we, addr, wdata, rdata, err, lat, en_cycles);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_ack(0, 2'b00, 64'h0);
        set_ack(1, 2'b00, 64'h0);
        repeat (3) @(negedge clk);
        checks++; if (bus0.m_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b required 0", bus0.m_rvalid); end
        checks++; if (bus0.m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", bus0.m_ready); end
        checks++; if (bus0.m_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", bus0.m_err); end
        checks++; if (bus0.m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", bus0.m_rdata); end
        checks++; if ({bus0.s_en, bus1.s_en, bus0.s_we} !== 6'h0) begin errors++; $display("FAIL reset_s_en: got %b required 0", {bus0.s_en, bus1.s_en, bus0.s_we}); end
        checks++; if ({bus0.s_addr, bus0.s_wdata} !== 128'h0) begin errors++; $display("FAIL reset_s_bus: got %h required 0", {bus0.s_addr, bus0.s_wdata}); end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_read();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        exp_t e;
        sb.push_back('{rdata: 32'hCAFE_0001, err: 1'b0, lat: 3});
        run_txn(0, 1'b0, 32'h0600_0010, 32'h0, 0, 1, 32'hCAFE_0001, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL read_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL read_err: got %b required %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL read_latency: got %0d required %0d", lat, e.lat); end
        checks++; if (eo !== 2'b01) begin errors++; $display("FAIL read_s_en: got %b required 01", eo); end
        checks++; if (af !== 64'h0000_0000_0600_0010) begin errors++; $display("FAIL read_s_addr: got %h required 0000000006000010", af); end
        checks++; if (wf !== 2'b00) begin errors++; $display("FAIL read_s_we: got %b required 00", wf); end
        checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL read_rvalid_width: second cycle got %b required 0", rv2); end
        repeat (3) @(negedge clk);
        checks++; if (bus0.m_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL read_rdata_hold: got %h required cafe0001", bus0.m_rdata); end
    endtask

    task automatic test_write();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 3});
        run_txn(0, 1'b1, 32'h0900_0004, 32'h0000_1234, 1, 1, 32'hDEAD_BEEF, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (eo !== 2'b10) begin errors++; $display("FAIL write_s_en: got %b required 10", eo); end
        checks++; if (wf !== 2'b10) begin errors++; $display("FAIL write_s_we: got %b required 10", wf); end
        checks++; if (wdf !== 64'h0000_1234_0000_0000) begin errors++; $display("FAIL write_s_wdata: got %h required 0000123400000000", wdf); end
        checks++; if (af !== 64'h0900_0004_0000_0000) begin errors++; $display("FAIL write_s_addr: got %h required 0900000400000000", af); end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL write_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL write_err: got %b required %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL write_latency: got %0d required %0d", lat, e.lat); end
    endtask

    task automatic test_unmapped();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
        run_txn(0, 1'b0, 32'h0700_0000, 32'h0, -1, -1, 32'h0, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (eo !== 2'b00) begin errors++; $display("FAIL unmapped_s_en: got %b required 00", eo); end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL unmapped_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL unmapped_err: got %b required %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL unmapped_latency: got %0d required %0d", lat, e.lat); end
    endtask

    task automatic test_timeout();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        exp_t e;
        // Slave 0 never acks: four BUSY cycles, then an error response
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 5});
        run_txn(0, 1'b0, 32'h0600_0020, 32'h0, 0, -1, 32'hAAAA_AAAA, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (enc !== 4) begin errors++; $display("FAIL timeout_s_en_cycles: got %0d required 4", enc); end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL timeout_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL timeout_err: got %b required %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL timeout_latency: got %0d required %0d", lat, e.lat); end
        // Ack lands on the very cycle the timeout would fire: the ack wins
        sb.push_back('{rdata: 32'h55AA_33CC, err: 1'b0, lat: 5});
        run_txn(0, 1'b0, 32'h0600_0024, 32'h0, 0, 3, 32'h55AA_33CC, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL ack_at_timeout_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL ack_at_timeout_err: got %b required %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL ack_at_timeout_latency: got %0d required %0d", lat, e.lat); end
    endtask

    task automatic test_spurious_ack();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        exp_t e;
        // Slave 1 acks constantly while slave 0 is the target
        sb.push_back('{rdata: 32'h1357_9BDF, err: 1'b0, lat: 4});
        run_txn(0, 1'b0, 32'h0600_0008, 32'h0, 0, 2, 32'h1357_9BDF, 2'b10,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL spurious_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL spurious_latency: got %0d required %0d", lat, e.lat); end
    endtask

    task automatic test_priority();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        exp_t e;
        // Both slaves decode 0x06: slave 0 takes it, slave 1 ack is ignored
        sb.push_back('{rdata: 32'h0BEE_F00D, err: 1'b0, lat: 3});
        run_txn(1, 1'b0, 32'h0600_0000, 32'h0, 0, 1, 32'h0BEE_F00D, 2'b10,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (eo !== 2'b01) begin errors++; $display("FAIL priority_s_en: got %b required 01", eo); end
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL priority_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL priority_latency: got %0d required %0d", lat, e.lat); end
        // Only slave 1 acks: nothing completes the transfer, so it times out
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 5});
        run_txn(1, 1'b0, 32'h0600_0000, 32'h0, 1, 0, 32'h7777_7777, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (eo !== 2'b01) begin errors++; $display("FAIL priority_only_s1_s_en: got %b required 01", eo); end
        checks++; if (er !== e.err) begin errors++; $display("FAIL priority_only_s1_err: got %b required %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL priority_only_s1_latency: got %0d required %0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        // m_en held high on an unmapped address: accept, respond, accept again
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        @(negedge clk);
        checks++; if (bus0.m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_first: got %b required 1", bus0.m_ready); end
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
        @(negedge clk);
        checks++; if (bus0.m_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp: got %b required 0", bus0.m_ready); end
        if (bus0.m_rvalid === 1'b1 && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++; if (bus0.m_err !== e.err) begin errors++; $display("FAIL b2b_err_first: got %b required %b", bus0.m_err, e.err); end
        end else begin
            checks++; errors++; $display("FAIL b2b_rvalid_first: got %b required 1", bus0.m_rvalid);
        end
        @(negedge clk);
        checks++; if (bus0.m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp: got %b required 1", bus0.m_ready); end
        checks++; if (bus0.m_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_after_resp: got %b required 0", bus0.m_rvalid); end
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        if (bus0.m_rvalid === 1'b1 && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++; if (bus0.m_err !== e.err) begin errors++; $display("FAIL b2b_err_second: got %b required %b", bus0.m_err, e.err); end
        end else begin
            checks++; errors++; $display("FAIL b2b_rvalid_second: got %b required 1", bus0.m_rvalid);
        end
        $display("txn back-to-back unmapped pair done");
    endtask

    task automatic test_reset_busy();
        int lat, enc; logic [1:0] eo, ef, wf; logic [63:0] af, wdf; logic [31:0] rd; logic er, rv2;
        logic saw_rvalid;
        exp_t e;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h0600_0040, 32'h0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (bus0.s_en !== 2'b01) begin errors++; $display("FAIL rst_busy_s_en_before: got %b required 01", bus0.s_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus0.s_en !== 2'b00) begin errors++; $display("FAIL rst_busy_s_en_drop: got %b required 00", bus0.s_en); end
        checks++; if (bus0.m_err !== 1'b0) begin errors++; $display("FAIL rst_busy_err_clear: got %b required 0", bus0.m_err); end
        saw_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_rvalid |= bus0.m_rvalid;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            saw_rvalid |= bus0.m_rvalid;
        end
        checks++; if (saw_rvalid !== 1'b0) begin errors++; $display("FAIL rst_busy_no_resp: m_rvalid got 1 required 0"); end
        $display("txn reset during BUSY");
        sb.push_back('{rdata: 32'hA5A5_0042, err: 1'b0, lat: 2});
        run_txn(0, 1'b0, 32'h0600_0044, 32'h0, 0, 0, 32'hA5A5_0042, 2'b00,
                lat, enc, eo, ef, wf, af, wdf, rd, er, rv2);
        e = sb.pop_front();
        checks++; if (rd !== e.rdata) begin errors++; $display("FAIL rst_busy_recover_rdata: got %h required %h", rd, e.rdata); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL rst_busy_recover_latency: got %0d required %0d", lat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_spurious_ack();
        test_priority();
        test_back_to_back();
        test_reset_busy();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
